// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide sequencer.
package mips_pkg;

   typedef enum logic [1:0] {
      OpMult  = 2'b00,
      OpMultu = 2'b01,
      OpDiv   = 2'b10,
      OpDivu  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StPrep  = 2'b01,
      StIter  = 2'b10,
      StFixup = 2'b11
   } muldiv_state_t;

   // Edges from accept to HI/LO update; busy is high for this many cycles.
   localparam int unsigned MULDIV_LATENCY = 34;

   function automatic logic op_is_div(input muldiv_op_t op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input muldiv_op_t op);
      return ~op[0];
   endfunction

   // Decode-stage mapping of SPECIAL funct codes onto the sequencer op.
   function automatic muldiv_op_t funct_to_op(input logic [5:0] funct);
      muldiv_op_t op;
      case (funct)
         6'b011000: op = OpMult;
         6'b011001: op = OpMultu;
         6'b011010: op = OpDiv;
         6'b011011: op = OpDivu;
         default:   op = OpMult;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   input  logic               i_bit,
   input  logic               i_div,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [2*WIDTH-1:0] w_mul;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_diff;

   always_comb begin
      // Multiply: acc = 2*acc + bit*multiplicand, multiplier consumed MSB first.
      w_mul = {i_acc[2*WIDTH-2:0], 1'b0} + (i_bit ? {{WIDTH{1'b0}}, i_opnd} : '0);

      // Divide: acc = {remainder, quotient}; dividend bits enter MSB first.
      w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_bit};
      w_diff   = w_rem_sh - {1'b0, i_opnd};

      if (!i_div) begin
         o_acc = w_mul;
      end else if (!w_diff[WIDTH]) begin
         o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
         o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mips_muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Fixed latency: accept, one prep cycle, ITERS iterations, one sign-fixup cycle.
module mips_muldiv_seq
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITERS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_rs_val,
   input  logic [WIDTH-1:0] i_rt_val,
   input  logic             i_mthi,
   input  logic             i_mtlo,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_zero
);

   localparam int unsigned CNT_W = $clog2(ITERS);

   muldiv_state_t      r_state;
   muldiv_state_t      w_state_next;
   muldiv_op_t         r_op;
   logic [WIDTH-1:0]   r_rs;
   logic [WIDTH-1:0]   r_rt;
   logic [WIDTH-1:0]   r_shift;
   logic [WIDTH-1:0]   r_opnd;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_res_neg;
   logic               r_rem_neg;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               r_div_zero;

   logic               w_accept;
   logic               w_mt_en;
   logic               w_rs_neg;
   logic               w_rt_neg;
   logic [WIDTH-1:0]   w_rs_mag;
   logic [WIDTH-1:0]   w_rt_mag;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               w_div_zero;
   logic [WIDTH-1:0]   w_hi_res;
   logic [WIDTH-1:0]   w_lo_res;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_mt_en      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_accept     = 1'b1;
               w_state_next = StPrep;
            end else begin
               w_mt_en = 1'b1;
            end
         end
         StPrep: w_state_next = StIter;
         StIter: begin
            if (r_cnt == CNT_W'(ITERS - 1)) begin
               w_state_next = StFixup;
            end
         end
         StFixup: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // ------------------------------------------------- operand conditioning
   always_comb begin
      w_rs_neg = op_is_signed(r_op) & r_rs[WIDTH-1];
      w_rt_neg = op_is_signed(r_op) & r_rt[WIDTH-1];
      w_rs_mag = w_rs_neg ? -r_rs : r_rs;
      w_rt_mag = w_rt_neg ? -r_rt : r_rt;
   end

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .i_bit  (r_shift[WIDTH-1]),
      .i_div  (op_is_div(r_op)),
      .o_acc  (w_acc_next)
   );

   // ------------------------------------------------------ sign fix-up
   always_comb begin
      w_prod     = r_res_neg ? -r_acc : r_acc;
      w_quo      = r_res_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem      = r_rem_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_div_zero = op_is_div(r_op) && (r_rt == '0);
      if (w_div_zero) begin
         w_hi_res = r_rs;
         w_lo_res = '1;
      end else if (op_is_div(r_op)) begin
         w_hi_res = w_rem;
         w_lo_res = w_quo;
      end else begin
         w_hi_res = w_prod[2*WIDTH-1:WIDTH];
         w_lo_res = w_prod[WIDTH-1:0];
      end
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op       <= OpMult;
         r_rs       <= '0;
         r_rt       <= '0;
         r_shift    <= '0;
         r_opnd     <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_res_neg  <= 1'b0;
         r_rem_neg  <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_op <= muldiv_op_t'(i_op);
                  r_rs <= i_rs_val;
                  r_rt <= i_rt_val;
               end else if (w_mt_en) begin
                  if (i_mthi) r_hi <= i_wdata;
                  if (i_mtlo) r_lo <= i_wdata;
               end
            end
            StPrep: begin
               // The shift register supplies the bit stream: multiplier or dividend.
               r_shift   <= op_is_div(r_op) ? w_rs_mag : w_rt_mag;
               r_opnd    <= op_is_div(r_op) ? w_rt_mag : w_rs_mag;
               r_res_neg <= w_rs_neg ^ w_rt_neg;
               r_rem_neg <= w_rs_neg;
               r_acc     <= '0;
               r_cnt     <= '0;
            end
            StIter: begin
               r_acc   <= w_acc_next;
               r_shift <= {r_shift[WIDTH-2:0], 1'b0};
               r_cnt   <= r_cnt + CNT_W'(1);
            end
            StFixup: begin
               r_hi       <= w_hi_res;
               r_lo       <= w_lo_res;
               r_done     <= 1'b1;
               r_div_zero <= w_div_zero;
            end
            default: ;
         endcase
      end
   end

   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
   assign o_busy     = (r_state != StIdle);
   assign o_done     = r_done;
   assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Scoreboard bench for mips_muldiv_seq: directed ops push expectations, a monitor checks on done.
module tb_mips_muldiv_seq;
   import mips_pkg::*;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        i_start;
   logic [1:0]  i_op;
   logic [31:0] i_rs_val;
   logic [31:0] i_rt_val;
   logic        i_mthi;
   logic        i_mtlo;
   logic [31:0] i_wdata;
   logic [31:0] o_hi;
   logic [31:0] o_lo;
   logic        o_busy;
   logic        o_done;
   logic        o_div_zero;

   int   n_vec;
   int   n_err;
   int   busy_cnt;
   exp_t exp_q[$];
   exp_t mon_e;

   mips_muldiv_seq dut (
      .clk        (clk),
      .reset      (reset),
      .i_start    (i_start),
      .i_op       (i_op),
      .i_rs_val   (i_rs_val),
      .i_rt_val   (i_rt_val),
      .i_mthi     (i_mthi),
      .i_mtlo     (i_mtlo),
      .i_wdata    (i_wdata),
      .o_hi       (o_hi),
      .o_lo       (o_lo),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_div_zero (o_div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt = 0;
      end else begin
         if (o_busy) busy_cnt++;
         if (o_div_zero && !o_done) begin
            n_vec++;
            n_err++;
            $display("FAIL div_zero_without_done: div_zero=%b done=%b", o_div_zero, o_done);
         end
         if (o_done) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: hi=%h lo=%h with empty scoreboard", o_hi, o_lo);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_hi", 64'(o_hi), 64'(mon_e.hi));
               check("sb_lo", 64'(o_lo), 64'(mon_e.lo));
               check("sb_div_zero", 64'(o_div_zero), 64'(mon_e.dz));
               check("sb_busy_cycles", 64'(busy_cnt), 64'(MULDIV_LATENCY));
            end
            busy_cnt = 0;
         end
      end
   end

   // Called at posedge+1 with the unit idle (or in its done cycle).
   task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic push, input logic [31:0] hi, input logic [31:0] lo,
                        input logic dz);
      i_start  = 1'b1;
      i_op     = op;
      i_rs_val = rs;
      i_rt_val = rt;
      if (push) exp_q.push_back(exp_t'({hi, lo, dz}));
      @(posedge clk); #1;
      i_start  = 1'b0;
      i_rs_val = $urandom();
      i_rt_val = $urandom();
      i_op     = 2'($urandom());
      check("busy_after_accept", 64'(o_busy), 64'd1);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 80; k++) begin
         if (o_done) break;
         @(posedge clk); #1;
      end
      if (!o_done) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: done=%b busy=%b after 80 cycles", o_done, o_busy);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] hi, input logic [31:0] lo, input logic dz);
      issue(op, rs, rt, 1'b1, hi, lo, dz);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ndone;
      n_vec    = 0;
      n_err    = 0;
      busy_cnt = 0;
      reset    = 1'b1;
      i_start  = 1'b0;
      i_op     = 2'b00;
      i_rs_val = '0;
      i_rt_val = '0;
      i_mthi   = 1'b0;
      i_mtlo   = 1'b0;
      i_wdata  = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", 64'(o_hi), 64'd0);
      check("rst_lo", 64'(o_lo), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_div_zero", 64'(o_div_zero), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Consecutive run_op calls issue in the done cycle: back-to-back throughput.
      run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op(OpMultu, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
      run_op(OpMult,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op(OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_op(OpMult,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
      run_op(OpDiv,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op(OpDiv,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_op(OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
      run_op(OpDivu,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
      run_op(OpDivu,  32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
      run_op(OpDivu,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1);
      run_op(OpDiv,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(o_done), 64'd0);
      check("idle_after_done", 64'(o_busy), 64'd0);

      // MTHI/MTLO in idle.
      i_mthi  = 1'b1;
      i_mtlo  = 1'b1;
      i_wdata = 32'h0000_1234;
      @(posedge clk); #1;
      i_mthi = 1'b0;
      i_mtlo = 1'b0;
      check("mt_both_hi", 64'(o_hi), 64'h1234);
      check("mt_both_lo", 64'(o_lo), 64'h1234);
      i_mthi  = 1'b1;
      i_wdata = 32'h0000_AAAA;
      @(posedge clk); #1;
      i_mthi = 1'b0;
      check("mthi_only_hi", 64'(o_hi), 64'hAAAA);
      check("mthi_only_lo", 64'(o_lo), 64'h1234);

      // start together with MT: start wins, MT dropped; MT and start while busy ignored.
      i_mthi  = 1'b1;
      i_mtlo  = 1'b1;
      i_wdata = 32'h0000_DEAD;
      issue(OpMultu, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0);
      i_mthi = 1'b0;
      i_mtlo = 1'b0;
      check("mt_dropped_hi", 64'(o_hi), 64'hAAAA);
      check("mt_dropped_lo", 64'(o_lo), 64'h1234);
      repeat (3) @(posedge clk);
      #1;
      i_start  = 1'b1;
      i_op     = OpDivu;
      i_rs_val = 32'd5;
      i_rt_val = 32'd0;
      i_mthi   = 1'b1;
      i_mtlo   = 1'b1;
      i_wdata  = 32'h0000_BEEF;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_mthi  = 1'b0;
      i_mtlo  = 1'b0;
      check("busy_mt_ignored_hi", 64'(o_hi), 64'hAAAA);
      check("busy_mt_ignored_lo", 64'(o_lo), 64'h1234);
      wait_done();
      @(posedge clk); #1;

      // Reset mid-operation aborts with no done pulse.
      issue(OpDivu, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", 64'(o_busy), 64'd0);
      check("abort_hi", 64'(o_hi), 64'd0);
      check("abort_lo", 64'(o_lo), 64'd0);
      check("abort_done", 64'(o_done), 64'd0);
      reset = 1'b0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (o_done) ndone++;
      end
      check("abort_no_done", 64'(ndone), 64'd0);

      run_op(OpDivu, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
      @(posedge clk); #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
